execute_mc: RTL
===============

Name: execute_mc

Overview:
- Parametrised successor of the single-cycle execute stage, sitting between ID and WB.
- Single-cycle classes: integer add/sub/compare, shift, logic.
- Adds an iterative multi-cycle multiplier, a Z/N/C/V flags register exported for branch resolution, and a correct valid/stall handshake that supports multi-cycle ops and downstream back-pressure.

Parameters:
WIDTH, 32, data word width; power of 2, at least 8
W_RD, 4, destination register number width
ADDR_W, 32, instruction address width
W_OPC, 4, sub-opcode width
MUL_STEP, 2, multiplier bits retired per cycle; power of 2 dividing WIDTH

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset; asynchronous, active-high
v_i  in  1  ID presents a valid op
stall_o  out  1  to ID: stage cannot accept this cycle
src_i  in  WIDTH  source operand
dest_i  in  WIDTH  destination operand value
wb_i  in  1  op writes rd
rd_num_i  in  W_RD  destination register number
dopc_i  in  4  one-hot class: [3]INT [2]SHIFT [1]LOGIC [0]MUL
opc_i  in  W_OPC  sub-opcode
origaddr_i  in  ADDR_W  op address
stall_i  in  1  WB back-pressure
v_o  out  1  result valid to WB
wb_o  out  1  write-back enable
rd_num_o  out  W_RD  destination register
rd_data_o  out  WIDTH  result
addr_o  out  ADDR_W  origaddr of the op in the output register
flags_o  out  4  {Z,N,C,V} register
busy_o  out  1  multiplier FSM not IDLE

Behaviour:
- Reset: all outputs and registers are 0; FSM is IDLE. Reset mid-multiply aborts the op and discards it.
- Output-register free: free = ~v_o | ~stall_i.
- stall_o = (state!=IDLE) | ~free. Accept = v_i & ~stall_o.
- When free and no result is loaded, v_o <= 0. When ~free, all output registers hold.
- Single-cycle op accepted at edge t: appears at v_o from edge t; latency 1.
- INT sub-opcodes:
  - 0 ADD: dest+src.
  - 1 SUB: dest-src; C = no-borrow.
  - 2 CMP: SUB with wb_o forced 0.
  - 3 ADC: dest+src+C.
  - INT updates Z, N, C, V. V is signed overflow.
- SHIFT sub-opcodes: 0 SLL, 1 SRL, 2 SRA, by src[log2(WIDTH)-1:0].
  - Shifts update Z and N.
  - C = last bit shifted out; C = 0 when the amount is 0.
  - V is unchanged.
- LOGIC sub-opcodes: 0 AND, 1 OR, 2 XOR, 3 NOT(src). Updates Z and N; C and V are unchanged.
- Undefined opc within a valid class: rd_data 0, wb_o 0, flags unchanged, v_o still asserted.
- Non-one-hot dopc (zero or multiple bits) with v_i: passes as a bubble with v_o=1, wb_o=0, rd_data 0, flags unchanged.
- MUL (opc 0 = low WIDTH bits of dest*src, unsigned), FSM IDLE -> RUN -> DONE -> IDLE:
  - Accept at edge t: latch operands, rd_num, wb, addr; counter = WIDTH/MUL_STEP; enter RUN.
  - RUN: each cycle adds MUL_STEP partial products; counter decrements.
  - Last iteration with free: load the output register and go to IDLE. The result is visible at edge t+WIDTH/MUL_STEP.
  - Last iteration without free: go to DONE and hold until free, then load.
  - MUL updates Z and N; C and V are unchanged.
- Flags update only when an op is loaded into the output register, so flags_o and v_o change on the same edge.
- An op following a flag-writer sees the already-updated flags, including back-to-back ADC.
- v_i with stall_o high is ignored; ID must hold its inputs.

Decomposition:
- Shared package execute_pkg holds:
  - class bit indices CLS_INT/SHIFT/LOGIC/MUL;
  - sub-opcode constants (OPC_ADD, OPC_SUB, OPC_CMP, OPC_ADC, OPC_SLL, OPC_SRL, OPC_SRA, OPC_AND, OPC_OR, OPC_XOR, OPC_NOT, OPC_MUL);
  - flag bit indices FLG_Z/N/C/V;
  - the FSM state enum.
- One sub-module, execute_mul_iter: holds the iterative multiplier with start/done/busy, parametrised by WIDTH and MUL_STEP.
- Single-cycle ALU logic stays in execute_mc.

Test Plan:
- ADD dest=0x7FFFFFFF, src=1, wb_i=1, rd 5 -> next edge v_o=1, rd_data_o=0x80000000, rd_num_o=5, flags Z0 N1 C0 V1.
- SUB 3-3 then ADC 0xFFFFFFFF+0 back-to-back, no stall -> first: rd 0, Z1, C1. Second: rd_data 0x00000000, C1, Z1.
- MUL 1234*5678 with MUL_STEP=2 -> stall_o high for 16 cycles; v_o rises 16 edges after accept; rd_data 7006652; busy_o high throughout.
- stall_i held high 3 cycles while v_o=1 and ID presents AND -> outputs frozen, stall_o=1, AND result appears the edge after stall_i falls.
- MUL finishing while stall_i=1 -> FSM enters DONE, result loaded on the first edge with stall_i=0, no data lost.
- rst asserted asynchronously mid-MUL -> all outputs 0 immediately, busy_o=0; a subsequent ADD completes normally.

Source files
------------

// File: rtl/execute_pkg.sv
// Shared constants for the multi-cycle execute stage: class bits, sub-opcodes,
// flag positions and the multiplier FSM state type.
package execute_pkg;

    localparam int CLS_MUL   = 0;
    localparam int CLS_LOGIC = 1;
    localparam int CLS_SHIFT = 2;
    localparam int CLS_INT   = 3;

    localparam int OPC_ADD = 0;
    localparam int OPC_SUB = 1;
    localparam int OPC_CMP = 2;
    localparam int OPC_ADC = 3;

    localparam int OPC_SLL = 0;
    localparam int OPC_SRL = 1;
    localparam int OPC_SRA = 2;

    localparam int OPC_AND = 0;
    localparam int OPC_OR  = 1;
    localparam int OPC_XOR = 2;
    localparam int OPC_NOT = 3;

    localparam int OPC_MUL = 0;

    // flags_o is {Z,N,C,V}
    localparam int FLG_V = 0;
    localparam int FLG_C = 1;
    localparam int FLG_N = 2;
    localparam int FLG_Z = 3;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} mul_state_t;

endpackage

// File: rtl/execute_mul_iter.sv
// Iterative shift-add multiplier retiring MUL_STEP multiplier bits per cycle.
// done pulses in the cycle the product may be loaded downstream (free high).
module execute_mul_iter
    import execute_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             free,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic             busy,
    output logic [WIDTH-1:0] result
);

    localparam int ITERS = WIDTH / MUL_STEP;
    localparam int CW    = $clog2(ITERS + 1);

    mul_state_t       state, state_nx;
    logic [WIDTH-1:0] mcand, mplier, acc, acc_nx;
    logic [CW-1:0]    cnt;
    logic             last;

    always_comb begin
        acc_nx = acc;
        for (int j = 0; j < MUL_STEP; j++)
            if (mplier[j]) acc_nx = acc_nx + (mcand << j);
    end

    assign last   = (state == ST_RUN) && (cnt == CW'(1));
    assign busy   = (state != ST_IDLE);
    assign done   = free && (last || state == ST_DONE);
    // in DONE the final sum already sits in acc; on the last RUN cycle it is acc_nx
    assign result = (state == ST_DONE) ? acc : acc_nx;

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start) state_nx = ST_RUN;
            ST_RUN:  if (last)  state_nx = free ? ST_IDLE : ST_DONE;
            ST_DONE: if (free)  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && start) begin
                mcand  <= a;
                mplier <= b;
                acc    <= '0;
                cnt    <= CW'(ITERS);
            end else if (state == ST_RUN) begin
                mcand  <= mcand << MUL_STEP;
                mplier <= mplier >> MUL_STEP;
                acc    <= acc_nx;
                cnt    <= cnt - CW'(1);
            end
        end
    end

endmodule

// File: rtl/execute_mc.sv
// Execute stage: single-cycle INT/SHIFT/LOGIC ALU, iterative MUL, {Z,N,C,V}
// flags register and a valid/stall handshake with WB back-pressure.
module execute_mc
    import execute_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int W_RD     = 4,
    parameter int ADDR_W   = 32,
    parameter int W_OPC    = 4,
    parameter int MUL_STEP = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              v_i,
    output logic              stall_o,
    input  logic [WIDTH-1:0]  src_i,
    input  logic [WIDTH-1:0]  dest_i,
    input  logic              wb_i,
    input  logic [W_RD-1:0]   rd_num_i,
    input  logic [3:0]        dopc_i,
    input  logic [W_OPC-1:0]  opc_i,
    input  logic [ADDR_W-1:0] origaddr_i,
    input  logic              stall_i,
    output logic              v_o,
    output logic              wb_o,
    output logic [W_RD-1:0]   rd_num_o,
    output logic [WIDTH-1:0]  rd_data_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [3:0]        flags_o,
    output logic              busy_o
);

    localparam int SH_W = $clog2(WIDTH);

    logic              free, accept, onehot, mul_start, load_sc, mul_done;
    logic [WIDTH-1:0]  mul_res, res;
    logic              wb_nx, upd_zn;
    logic [3:0]        flg_nx, mul_flags;
    logic              mul_wb;
    logic [W_RD-1:0]   mul_rd;
    logic [ADDR_W-1:0] mul_addr;

    logic              is_sub, add_c, add_v;
    logic [WIDTH-1:0]  add_b, add_r, sh_tmp;
    logic [SH_W-1:0]   sh;

    assign free      = ~v_o | ~stall_i;
    assign stall_o   = busy_o | ~free;
    assign accept    = v_i & ~stall_o;
    assign onehot    = $onehot(dopc_i);
    assign mul_start = accept & onehot & dopc_i[CLS_MUL] & (int'(opc_i) == OPC_MUL);
    assign load_sc   = accept & ~mul_start;

    execute_mul_iter #(.WIDTH(WIDTH), .MUL_STEP(MUL_STEP)) u_mul (
        .clk    (clk),
        .rst    (rst),
        .start  (mul_start),
        .free   (free),
        .a      (dest_i),
        .b      (src_i),
        .done   (mul_done),
        .busy   (busy_o),
        .result (mul_res)
    );

    // subtract as dest + ~src + 1 so carry-out is the no-borrow flag directly
    assign is_sub = (int'(opc_i) == OPC_SUB) || (int'(opc_i) == OPC_CMP);
    assign add_b  = is_sub ? ~src_i : src_i;
    assign {add_c, add_r} = {1'b0, dest_i} + {1'b0, add_b}
                          + {{WIDTH{1'b0}}, is_sub | ((int'(opc_i) == OPC_ADC) & flags_o[FLG_C])};
    assign add_v  = (dest_i[WIDTH-1] == add_b[WIDTH-1]) && (add_r[WIDTH-1] != dest_i[WIDTH-1]);
    assign sh     = src_i[SH_W-1:0];

    always_comb begin
        res    = '0;
        wb_nx  = 1'b0;
        upd_zn = 1'b0;
        flg_nx = flags_o;
        sh_tmp = '0;
        if (onehot && dopc_i[CLS_INT]) begin
            case (int'(opc_i))
                OPC_ADD, OPC_SUB, OPC_CMP, OPC_ADC: begin
                    res           = add_r;
                    wb_nx         = wb_i && (int'(opc_i) != OPC_CMP);
                    upd_zn        = 1'b1;
                    flg_nx[FLG_C] = add_c;
                    flg_nx[FLG_V] = add_v;
                end
                default: ;
            endcase
        end else if (onehot && dopc_i[CLS_SHIFT]) begin
            case (int'(opc_i))
                OPC_SLL: begin
                    res    = dest_i << sh;
                    sh_tmp = dest_i >> (WIDTH - int'(sh));
                end
                OPC_SRL: begin
                    res    = dest_i >> sh;
                    sh_tmp = dest_i >> (int'(sh) - 1);
                end
                OPC_SRA: begin
                    res    = $signed(dest_i) >>> sh;
                    sh_tmp = dest_i >> (int'(sh) - 1);
                end
                default: ;
            endcase
            if (int'(opc_i) == OPC_SLL || int'(opc_i) == OPC_SRL || int'(opc_i) == OPC_SRA) begin
                wb_nx         = wb_i;
                upd_zn        = 1'b1;
                flg_nx[FLG_C] = (sh != '0) && sh_tmp[0];
            end
        end else if (onehot && dopc_i[CLS_LOGIC]) begin
            upd_zn = 1'b1;
            wb_nx  = wb_i;
            case (int'(opc_i))
                OPC_AND: res = dest_i & src_i;
                OPC_OR:  res = dest_i | src_i;
                OPC_XOR: res = dest_i ^ src_i;
                OPC_NOT: res = ~src_i;
                default: begin
                    upd_zn = 1'b0;
                    wb_nx  = 1'b0;
                end
            endcase
        end
        if (upd_zn) begin
            flg_nx[FLG_Z] = (res == '0);
            flg_nx[FLG_N] = res[WIDTH-1];
        end
    end

    always_comb begin
        mul_flags        = flags_o;
        mul_flags[FLG_Z] = (mul_res == '0);
        mul_flags[FLG_N] = mul_res[WIDTH-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_o       <= 1'b0;
            wb_o      <= 1'b0;
            rd_num_o  <= '0;
            rd_data_o <= '0;
            addr_o    <= '0;
            flags_o   <= '0;
            mul_wb    <= 1'b0;
            mul_rd    <= '0;
            mul_addr  <= '0;
        end else begin
            if (mul_start) begin
                mul_wb   <= wb_i;
                mul_rd   <= rd_num_i;
                mul_addr <= origaddr_i;
            end
            if (free) begin
                if (load_sc) begin
                    v_o       <= 1'b1;
                    wb_o      <= wb_nx;
                    rd_num_o  <= rd_num_i;
                    rd_data_o <= res;
                    addr_o    <= origaddr_i;
                    flags_o   <= flg_nx;
                end else if (mul_done) begin
                    v_o       <= 1'b1;
                    wb_o      <= mul_wb;
                    rd_num_o  <= mul_rd;
                    rd_data_o <= mul_res;
                    addr_o    <= mul_addr;
                    flags_o   <= mul_flags;
                end else begin
                    v_o <= 1'b0;
                end
            end
        end
    end

endmodule
